// File: rtl/pcm_wr_sched_if.sv
// Bus bundle for pcm_wr_sched: receiver pulses, PCM strobe, inserter ports,
// the downstream write port and status outputs.
interface pcm_wr_sched_if;
  logic        sync_pulse_i;
  logic        end_pulse_i;
  logic [7:0]  pcm_data_i;
  logic        pcm_req_i;
  logic [7:0]  head_data_i;
  logic        head_req_i;
  logic        head_flag_i;
  logic [7:0]  timer_data_i;
  logic        timer_req_i;
  logic        timer_flag_i;
  logic        fifo_full_i;
  logic        head_start_o;
  logic        timer_start_o;
  logic [7:0]  wr_data_o;
  logic        wr_req_o;
  logic [15:0] drop_cnt_o;
  logic        tmo_o;

  modport master (
    output sync_pulse_i, end_pulse_i, pcm_data_i, pcm_req_i,
           head_data_i, head_req_i, head_flag_i,
           timer_data_i, timer_req_i, timer_flag_i, fifo_full_i,
    input  head_start_o, timer_start_o, wr_data_o, wr_req_o, drop_cnt_o, tmo_o
  );

  modport slave (
    input  sync_pulse_i, end_pulse_i, pcm_data_i, pcm_req_i,
           head_data_i, head_req_i, head_flag_i,
           timer_data_i, timer_req_i, timer_flag_i, fifo_full_i,
    output head_start_o, timer_start_o, wr_data_o, wr_req_o, drop_cnt_o, tmo_o
  );
endinterface

// File: rtl/pcm_wr_sched.sv
// Downstream write-port scheduler: head/timer inserters take the port in turn,
// PCM bytes are buffered meanwhile. Optional inserter timeout: PCM_SCHED_TIMEOUT_EN.
module pcm_wr_sched #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  pcm_wr_sched_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, HEAD_WAIT, HEAD_RUN, TMR_WAIT, TMR_RUN} state_t;

  state_t              state, state_nxt;
  logic                head_pend, timer_pend;
  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr, rptr;
  logic                empty, full, push, pop, drop;
  logic                head_start, timer_start;
  logic                wr_req_q, wr_req_nxt;
  logic [7:0]          wr_data_q, wr_data_nxt;
  logic [15:0]         drop_cnt;
  logic                tmo_hit;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                 (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign push  = bus.pcm_req_i && (!full || pop);
  assign drop  = bus.pcm_req_i && full && !pop;

`ifdef PCM_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_q, wait_st, wait_flag;

  assign wait_st   = (state == HEAD_WAIT) || (state == TMR_WAIT);
  assign wait_flag = (state == HEAD_WAIT) ? bus.head_flag_i : bus.timer_flag_i;
  assign tmo_hit   = wait_st && !wait_flag && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_cnt <= wait_st ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end
  assign bus.tmo_o = tmo_q;
`else
  assign tmo_hit   = 1'b0;
  assign bus.tmo_o = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    head_start  = 1'b0;
    timer_start = 1'b0;
    pop         = 1'b0;
    wr_req_nxt  = 1'b0;
    wr_data_nxt = wr_data_q;
    case (state)
      IDLE: begin
        if (head_pend) begin
          head_start = 1'b1;
          state_nxt  = HEAD_WAIT;
        end else if (timer_pend) begin
          timer_start = 1'b1;
          state_nxt   = TMR_WAIT;
        end else if (!empty && !bus.fifo_full_i) begin
          pop         = 1'b1;
          wr_req_nxt  = 1'b1;
          wr_data_nxt = mem[rptr[DEPTH_LOG2-1:0]];
        end
      end
      // Inserter strobes pass through in WAIT too, so a write issued in the
      // same cycle the flag rises is not lost.
      HEAD_WAIT, HEAD_RUN: begin
        wr_req_nxt  = bus.head_req_i;
        wr_data_nxt = bus.head_data_i;
        if (state == HEAD_WAIT) begin
          if (tmo_hit)               state_nxt = IDLE;
          else if (bus.head_flag_i)  state_nxt = HEAD_RUN;
        end else if (!bus.head_flag_i) state_nxt = IDLE;
      end
      TMR_WAIT, TMR_RUN: begin
        wr_req_nxt  = bus.timer_req_i;
        wr_data_nxt = bus.timer_data_i;
        if (state == TMR_WAIT) begin
          if (tmo_hit)               state_nxt = IDLE;
          else if (bus.timer_flag_i) state_nxt = TMR_RUN;
        end else if (!bus.timer_flag_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      head_pend  <= 1'b0;
      timer_pend <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      head_pend  <= (head_pend && !head_start) || bus.end_pulse_i;
      timer_pend <= (timer_pend && !timer_start) || bus.sync_pulse_i;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      wr_req_q   <= wr_req_nxt;
      wr_data_q  <= wr_data_nxt;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[DEPTH_LOG2-1:0]] <= bus.pcm_data_i;
  end

  assign bus.head_start_o  = head_start;
  assign bus.timer_start_o = timer_start;
  assign bus.wr_req_o      = wr_req_q;
  assign bus.wr_data_o     = wr_data_q;
  assign bus.drop_cnt_o    = drop_cnt;
endmodule
